// File: rtl/matrix_scan_ctrl.sv
// ---------------------------------------------------------------------------
// matrix_scan_ctrl
//
// Scans a Rows x Cols sensor matrix one pixel at a time.
// For each pixel the controller selects the row/column, waits SettleCycles
// clocks for the analog mux to settle, fires a one-clock convert strobe, and
// then waits for the converter to report completion. The column index is the
// inner loop. After the last pixel it either starts the next frame at (0,0)
// (continuous mode) or returns to IDLE.
//
// Ports
//   clk_i          sole clock, rising edge
//   rst_ni         synchronous active-low reset
//   start_i        request a frame scan (only looked at in IDLE)
//   continuous_i   1 = start the next frame right after the last pixel
//   abort_i        abandon the scan, back to IDLE next clock
//   adc_done_i     converter finished the current pixel (only looked at in WAIT)
//   row_o, col_o   current row / column select
//   mux_en_o       matrix mux enable, high whenever not IDLE
//   adc_start_o    one-clock convert strobe (high only in CONV)
//   busy_o         high whenever not IDLE
//   frame_done_o   one-clock pulse after the last pixel completes
// ---------------------------------------------------------------------------
module matrix_scan_ctrl #(
   parameter int Rows         = 2,
   parameter int Cols         = 2,
   parameter int Width        = 5,
   parameter int SettleCycles = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             continuous_i,
   input  logic             abort_i,
   input  logic             adc_done_i,
   output logic [Width-1:0] row_o,
   output logic [Width-1:0] col_o,
   output logic             mux_en_o,
   output logic             adc_start_o,
   output logic             busy_o,
   output logic             frame_done_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CONV   = 2'd2,
      WAIT   = 2'd3
   } state_e;

   // A one-clock settle time still needs a 1-bit counter to exist.
   localparam int CntW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
   localparam logic [CntW-1:0]  SettleLast = CntW'(SettleCycles - 1);
   localparam logic [Width-1:0] RowLast    = Width'(Rows - 1);
   localparam logic [Width-1:0] ColLast    = Width'(Cols - 1);

   state_e           state_q;
   logic [Width-1:0] row_q;
   logic [Width-1:0] col_q;
   logic [CntW-1:0]  cnt_q;
   logic             frame_done_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         row_q        <= '0;
         col_q        <= '0;
         cnt_q        <= '0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         if (abort_i && (state_q != IDLE)) begin
            // Abort wins over everything, including a same-cycle adc_done_i.
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start_i) begin
                     state_q <= SETTLE;
                     row_q   <= '0;
                     col_q   <= '0;
                     cnt_q   <= '0;
                  end
               end
               SETTLE: begin
                  if (cnt_q == SettleLast) begin
                     state_q <= CONV;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               CONV: begin
                  state_q <= WAIT;
               end
               WAIT: begin
                  if (adc_done_i) begin
                     state_q <= SETTLE;
                     cnt_q   <= '0;
                     if (col_q != ColLast) begin
                        col_q <= col_q + 1'b1;
                     end else begin
                        col_q <= '0;
                        if (row_q != RowLast) begin
                           row_q <= row_q + 1'b1;
                        end else begin
                           // Last pixel: indices already wrapped to (0,0).
                           row_q        <= '0;
                           frame_done_q <= 1'b1;
                           if (!continuous_i) begin
                              state_q <= IDLE;
                           end
                        end
                     end
                  end
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign row_o        = row_q;
   assign col_o        = col_q;
   assign mux_en_o     = (state_q != IDLE);
   assign busy_o       = (state_q != IDLE);
   assign adc_start_o  = (state_q == CONV);
   assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for matrix_scan_ctrl. Two instances: A with default parameters and
// B with Rows=1, Cols=3, SettleCycles=1. Expected pixel coordinates are
// queued when a scan is started and popped on every convert strobe.
// ---------------------------------------------------------------------------
module tb_matrix_scan_ctrl;

   localparam int W = 5;

   typedef struct packed {
      int r;
      int c;
   } pix_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic check_eq(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   logic rst_n = 1'b0;

   // ---------------- instance A (defaults) ----------------
   logic         start_a = 1'b0, cont_a = 1'b0, abort_a = 1'b0;
   logic         auto_a = 1'b1, man_a = 1'b0, resp_a = 1'b0;
   logic         done_a;
   logic [W-1:0] row_a, col_a;
   logic         mux_a, conv_a, busy_a, fd_a;
   assign done_a = auto_a ? resp_a : man_a;

   matrix_scan_ctrl u_dut_a (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start_a),
      .continuous_i (cont_a),
      .abort_i      (abort_a),
      .adc_done_i   (done_a),
      .row_o        (row_a),
      .col_o        (col_a),
      .mux_en_o     (mux_a),
      .adc_start_o  (conv_a),
      .busy_o       (busy_a),
      .frame_done_o (fd_a)
   );

   // ---------------- instance B (1x3, settle 1) ----------------
   logic         start_b = 1'b0, resp_b = 1'b0;
   logic         cont_b = 1'b0, abort_b = 1'b0;
   logic [W-1:0] row_b, col_b;
   logic         mux_b, conv_b, busy_b, fd_b;

   matrix_scan_ctrl #(.Rows(1), .Cols(3), .Width(W), .SettleCycles(1)) u_dut_b (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start_b),
      .continuous_i (cont_b),
      .abort_i      (abort_b),
      .adc_done_i   (resp_b),
      .row_o        (row_b),
      .col_o        (col_b),
      .mux_en_o     (mux_b),
      .adc_start_o  (conv_b),
      .busy_o       (busy_b),
      .frame_done_o (fd_b)
   );

   // Converter models: adc_done two cycles after each convert strobe.
   int cd_a = 0, cd_b = 0;
   always @(negedge clk) begin
      resp_a = 1'b0;
      if (cd_a != 0) begin
         cd_a--;
         if (cd_a == 0) resp_a = 1'b1;
      end
      if (conv_a) cd_a = 2;
   end
   always @(negedge clk) begin
      resp_b = 1'b0;
      if (cd_b != 0) begin
         cd_b--;
         if (cd_b == 0) resp_b = 1'b1;
      end
      if (conv_b) cd_b = 2;
   end

   // Scoreboards
   pix_t q_a[$];
   pix_t q_b[$];
   int conv_cnt_a = 0, fd_cnt_a = 0, conv_cnt_b = 0, fd_cnt_b = 0;

   always @(negedge clk) begin
      pix_t p;
      if (conv_a) begin
         conv_cnt_a++;
         if (q_a.size() == 0) check_eq("a_unexpected_conv", 1, 0);
         else begin
            p = q_a.pop_front();
            check_eq("a_row", int'(row_a), p.r);
            check_eq("a_col", int'(col_a), p.c);
         end
      end
      if (fd_a) fd_cnt_a++;
   end
   always @(negedge clk) begin
      pix_t p;
      if (conv_b) begin
         conv_cnt_b++;
         if (q_b.size() == 0) check_eq("b_unexpected_conv", 1, 0);
         else begin
            p = q_b.pop_front();
            check_eq("b_row", int'(row_b), p.r);
            check_eq("b_col", int'(col_b), p.c);
         end
      end
      if (fd_b) fd_cnt_b++;
   end

   task automatic push_a(input int r, input int c);
      pix_t p;
      p.r = r;
      p.c = c;
      q_a.push_back(p);
   endtask

   task automatic push_b(input int r, input int c);
      pix_t p;
      p.r = r;
      p.c = c;
      q_b.push_back(p);
   endtask

   task automatic check_idle_a(input string tag);
      check_eq({tag, "_busy"},  int'(busy_a), 0);
      check_eq({tag, "_mux"},   int'(mux_a),  0);
      check_eq({tag, "_conv"},  int'(conv_a), 0);
      check_eq({tag, "_fd"},    int'(fd_a),   0);
      check_eq({tag, "_row"},   int'(row_a),  0);
      check_eq({tag, "_col"},   int'(col_a),  0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen, drops, base_conv, base_fd, i;

      // ---------------- reset ----------------
      repeat (3) @(negedge clk);
      check_idle_a("reset");
      check_eq("reset_b_busy", int'(busy_b), 0);
      rst_n = 1'b1;

      // ---------------- single frame, latency ----------------
      while (cyc < 10) @(negedge clk);
      push_a(0, 0); push_a(0, 1); push_a(1, 0); push_a(1, 1);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      check_eq("lat_busy_n1", int'(busy_a), 1);
      check_eq("lat_mux_n1",  int'(mux_a),  1);
      check_eq("lat_conv_n1", int'(conv_a), 0);
      for (int k = 2; k <= 5; k++) begin
         @(negedge clk);
         check_eq("lat_conv", int'(conv_a), (k == 5) ? 1 : 0);
      end
      i = 0;
      while (!fd_a && i < 200) begin
         @(negedge clk);
         i++;
      end
      check_eq("f1_fd_seen", int'(fd_a), 1);
      check_eq("f1_idle_busy", int'(busy_a), 0);
      check_eq("f1_idle_row", int'(row_a), 0);
      check_eq("f1_idle_col", int'(col_a), 0);
      @(negedge clk);
      check_eq("f1_fd_single", int'(fd_a), 0);
      check_eq("f1_conv_cnt", conv_cnt_a, 4);
      check_eq("f1_fd_cnt", fd_cnt_a, 1);
      check_eq("f1_q_empty", q_a.size(), 0);

      // ---------------- continuous, two frames ----------------
      repeat (3) @(negedge clk);
      base_conv = conv_cnt_a;
      base_fd   = fd_cnt_a;
      for (int f = 0; f < 2; f++) begin
         push_a(0, 0); push_a(0, 1); push_a(1, 0); push_a(1, 1);
      end
      cont_a  = 1'b1;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      seen  = 0;
      drops = 0;
      for (int k = 0; k < 400 && seen < 2; k++) begin
         if (fd_a) begin
            seen++;
            if (seen == 1) begin
               check_eq("cont_f1_busy", int'(busy_a), 1);
               check_eq("cont_f1_row", int'(row_a), 0);
               check_eq("cont_f1_col", int'(col_a), 0);
               cont_a = 1'b0;
            end
         end else if (!busy_a) begin
            drops++;
         end
         if (seen < 2) @(negedge clk);
      end
      check_eq("cont_frames", seen, 2);
      check_eq("cont_busy_drops", drops, 0);
      check_eq("cont_end_busy", int'(busy_a), 0);
      @(negedge clk);
      check_eq("cont_conv_cnt", conv_cnt_a - base_conv, 8);
      check_eq("cont_fd_cnt", fd_cnt_a - base_fd, 2);
      check_eq("cont_q_empty", q_a.size(), 0);

      // ---------------- abort in WAIT at (1,0) with adc_done ----------------
      repeat (3) @(negedge clk);
      base_fd = fd_cnt_a;
      push_a(0, 0); push_a(0, 1); push_a(1, 0);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      i = 0;
      while (!(conv_a && row_a == 1 && col_a == 0) && i < 200) begin
         @(negedge clk);
         i++;
      end
      check_eq("abort_reach_10", int'(conv_a), 1);
      @(negedge clk);
      @(negedge clk);
      // Converter model raises adc_done in this same cycle.
      abort_a = 1'b1;
      @(negedge clk);
      abort_a = 1'b0;
      check_idle_a("abort");
      repeat (4) @(negedge clk);
      check_eq("abort_no_fd", fd_cnt_a - base_fd, 0);
      check_eq("abort_q_empty", q_a.size(), 0);

      // ---------------- reset during SETTLE at (0,1) ----------------
      push_a(0, 0);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      i = 0;
      while (!(col_a == 1) && i < 200) begin
         @(negedge clk);
         i++;
      end
      check_eq("rst_reach_01_col", int'(col_a), 1);
      check_eq("rst_reach_01_conv", int'(conv_a), 0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_idle_a("midrst");
      check_eq("midrst_q_empty", q_a.size(), 0);

      // adc_done held high in IDLE, SETTLE and CONV must not move indices.
      auto_a = 1'b0;
      man_a  = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_eq("idle_done_busy", int'(busy_a), 0);
         check_eq("idle_done_col", int'(col_a), 0);
      end
      push_a(0, 0);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      i = 0;
      while (!conv_a && i < 20) begin
         check_eq("settle_done_col", int'(col_a), 0);
         @(negedge clk);
         i++;
      end
      check_eq("settle_done_reach_conv", int'(conv_a), 1);
      man_a = 1'b0;
      @(negedge clk);
      check_eq("wait_busy", int'(busy_a), 1);
      check_eq("wait_col", int'(col_a), 0);
      check_eq("wait_conv", int'(conv_a), 0);
      abort_a = 1'b1;
      @(negedge clk);
      abort_a = 1'b0;
      auto_a  = 1'b1;
      check_eq("cleanup_busy", int'(busy_a), 0);
      check_eq("cleanup_q_empty", q_a.size(), 0);

      // ---------------- instance B: 1x3, settle 1 ----------------
      repeat (3) @(negedge clk);
      push_b(0, 0); push_b(0, 1); push_b(0, 2);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      check_eq("b_busy", int'(busy_b), 1);
      i = 0;
      while (!fd_b && i < 200) begin
         @(negedge clk);
         i++;
      end
      check_eq("b_fd_seen", int'(fd_b), 1);
      check_eq("b_conv_cnt_at_fd", conv_cnt_b, 3);
      check_eq("b_idle_busy", int'(busy_b), 0);
      check_eq("b_idle_col", int'(col_b), 0);
      @(negedge clk);
      check_eq("b_fd_cnt", fd_cnt_b, 1);
      check_eq("b_q_empty", q_b.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/matrix_scan_ctrl.md
MATRIX_SCAN_CTRL -- requirements
Module: matrix_scan_ctrl

Interface
REQ-001 SHALL have parameter Rows, default 2, number of matrix rows scanned (>=1).
REQ-002 SHALL have parameter Cols, default 2, number of matrix columns scanned (>=1).
REQ-003 SHALL have parameter Width, default 5, width of row and column index outputs; Rows and Cols SHALL each be <= 2**Width.
REQ-004 SHALL have parameter SettleCycles, default 4, mux settling delay in clocks (>=1).
REQ-005 SHALL use one clock and a synchronous, active-low reset.
REQ-006 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-007 rst_ni  input  1  synchronous active-low reset, sampled on rising clk_i.
REQ-008 start_i  input  1  request a frame scan; sampled only in IDLE.
REQ-009 continuous_i  input  1  1 = restart a new frame after the last pixel; sampled at the end of the frame.
REQ-010 abort_i  input  1  abandon the scan immediately.
REQ-011 adc_done_i  input  1  converter finished the current pixel; sampled only in WAIT.
REQ-012 row_o  output  Width  current row select.
REQ-013 col_o  output  Width  current column select.
REQ-014 mux_en_o  output  1  matrix mux enable; high in every state except IDLE.
REQ-015 adc_start_o  output  1  single-cycle convert strobe.
REQ-016 busy_o  output  1  high in every state except IDLE.
REQ-017 frame_done_o  output  1  single-cycle pulse when the last pixel completes.

Function
REQ-018 SHALL implement the FSM states IDLE, SETTLE, CONV, WAIT, registered; all outputs SHALL be registered or decoded from state only.
REQ-019 IDLE: start_i=1 -> SETTLE with row_o=0, col_o=0, settle counter cleared; otherwise remain in IDLE.
REQ-020 SETTLE SHALL last exactly SettleCycles clocks, then go to CONV.
REQ-021 CONV SHALL last exactly one clock with adc_start_o=1, then go to WAIT; adc_start_o SHALL be 0 in all other states.
REQ-022 WAIT: remain in WAIT while adc_done_i=0; adc_done_i=1 completes the pixel.
REQ-023 Scan order: column index innermost; on pixel completion with col_o<Cols-1, increment col_o and go to SETTLE; with col_o=Cols-1 and row_o<Rows-1, set col_o=0, increment row_o and go to SETTLE.
REQ-024 Last pixel (row_o=Rows-1, col_o=Cols-1) completion SHALL assert frame_done_o for one cycle; continuous_i=1 -> SETTLE at (0,0); continuous_i=0 -> IDLE with row_o=0, col_o=0.
REQ-025 Indices SHALL never exceed Rows-1 / Cols-1; no wrap through unused index values.
REQ-026 Latency: start_i high in cycle n -> busy_o high from cycle n+1, first adc_start_o in cycle n+1+SettleCycles.
REQ-027 abort_i=1 in any non-IDLE state SHALL go to IDLE next clock with row_o=0, col_o=0, no frame_done_o pulse; abort_i SHALL take priority over adc_done_i in the same cycle.
REQ-028 adc_done_i asserted in SETTLE, CONV or IDLE SHALL be ignored.
REQ-029 Rows=1 and Cols=1 SHALL be legal; every pixel completion is then the last pixel.

Reset
REQ-030 rst_ni=0 on a rising edge SHALL force IDLE, row_o=0, col_o=0, settle counter=0, mux_en_o=0, adc_start_o=0, busy_o=0, frame_done_o=0, overriding all other inputs, including mid-scan.

Verification
REQ-031 Defaults, start_i pulse, adc_done_i 2 cycles after each adc_start_o, continuous_i=0 -> (row,col) sequence (0,0),(0,1),(1,0),(1,1); 4 adc_start_o pulses; one frame_done_o; return to IDLE.
REQ-032 start_i at cycle 10 -> busy_o=1 at cycle 11, adc_start_o=1 only at cycle 15.
REQ-033 continuous_i=1 for 2 frames -> frame_done_o pulses twice; indices return to (0,0) without passing through IDLE (busy_o stays 1).
REQ-034 abort_i in WAIT at (1,0) together with adc_done_i -> IDLE next cycle, indices (0,0), no frame_done_o.
REQ-035 rst_ni=0 during SETTLE at (0,1) -> all outputs at reset values next cycle; adc_done_i pulses in IDLE/SETTLE -> no index change.
REQ-036 Rows=1, Cols=3, SettleCycles=1 -> columns 0,1,2 at row 0; frame_done_o after third adc_done_i.
